// File: rtl/seven_segment_scan.sv
// -----------------------------------------------------------------------------
// seven_segment_scan
//   Time-multiplexed driver for a DIGITS-wide seven-segment display.
//   A prescaler divides clk into digit slots. Each slot opens with GUARD dark
//   cycles to hide ghosting while the anodes switch, then shows one digit.
//   New data is written to a shadow register by a load strobe. The shadow is
//   copied to the active register only at a frame boundary, so a frame can
//   never show a mix of old and new digits.
//
// Parameters
//   DIGITS      1..8        number of multiplexed digits
//   REFRESH_DIV 4..2^20     clk cycles per digit slot
//   GUARD       1..DIV-2    dark cycles at the start of each slot
//   ACTIVE_LOW  0/1         1: seg/an drive 0 for lit/selected
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   value   in   4*DIGITS  hex nibble per digit, digit 0 rightmost
//   dp_in   in   DIGITS    decimal point per digit
//   blank   in   DIGITS    force digit dark (DP included)
//   load    in   1         capture value/dp_in/blank into the shadow register
//   seg     out  8         segments A..G = bit0..6, DP = bit7 (registered)
//   an      out  DIGITS    one-hot digit select (registered)
//   frame   out  1         high in the last cycle of each frame
//
// Optional feature
//   SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN : when defined, leading zero digits
//   (from the top digit down to the first nonzero one) are suppressed. Digit 0
//   is never suppressed. DP still shows on suppressed digits.
// -----------------------------------------------------------------------------

// Per-digit lane: decodes one nibble into an active-high segment pattern.
module seven_segment_scan_lane (
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  input  logic       i_blank,
  input  logic       i_lz,
  output logic [7:0] o_seg
);

  logic [6:0] w_glyph;

  always_comb begin
    w_glyph = 7'h00;
    case (i_nib)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      4'hF: w_glyph = 7'h71;
      default: w_glyph = 7'h00;
    endcase
  end

  // The blank input darkens everything. Leading-zero suppression keeps the DP.
  always_comb begin
    if (i_blank)   o_seg = 8'h00;
    else if (i_lz) o_seg = {i_dp, 7'h00};
    else           o_seg = {i_dp, w_glyph};
  end

endmodule

module seven_segment_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 16384,
  parameter int GUARD       = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_GUARD = PRE_W'(GUARD);
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);

  // Inactive levels. Polarity is applied by XOR just ahead of the output flops.
  localparam logic [7:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seven_segment_scan: DIGITS out of range 1..8");
  end
  if (REFRESH_DIV < 4 || REFRESH_DIV > (1 << 20)) begin : g_bad_div
    $error("seven_segment_scan: REFRESH_DIV out of range 4..2^20");
  end
  if (GUARD < 1 || GUARD > REFRESH_DIV - 2) begin : g_bad_guard
    $error("seven_segment_scan: GUARD out of range 1..REFRESH_DIV-2");
  end

  // Timing state
  logic [PRE_W-1:0]       r_presc;
  logic [IDX_W-1:0]       r_idx;
  logic [0:0]             r_state;

  // Shadow (written by load) and active (what the current frame displays)
  logic [4*DIGITS-1:0]    r_sh_val,   r_act_val;
  logic [DIGITS-1:0]      r_sh_dp,    r_act_dp;
  logic [DIGITS-1:0]      r_sh_blank, r_act_blank;

  logic [7:0]             r_seg;
  logic [DIGITS-1:0]      r_an;

  logic                   w_wrap;
  logic                   w_frame_bdry;
  logic [PRE_W-1:0]       w_presc_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [0:0]             w_state_nxt;
  logic [4*DIGITS-1:0]    w_act_val_nxt;
  logic [DIGITS-1:0]      w_act_dp_nxt;
  logic [DIGITS-1:0]      w_act_blank_nxt;
  logic [DIGITS-1:0]      w_lz;
  logic [DIGITS-1:0][7:0] w_lane_seg;
  logic [7:0]             w_seg_hi;
  logic [DIGITS-1:0]      w_an_hi;

  assign w_wrap       = (r_presc == PRE_MAX);
  assign w_frame_bdry = w_wrap && (r_idx == IDX_MAX);
  assign w_presc_nxt  = w_wrap ? '0 : r_presc + 1'b1;
  assign w_idx_nxt    = !w_wrap ? r_idx : ((r_idx == IDX_MAX) ? '0 : r_idx + 1'b1);

  // frame is driven only by registered state. It is high in the cycle whose
  // closing edge loads the active register.
  assign frame = w_frame_bdry;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_GUARD: if (w_presc_nxt >= PRE_GUARD) w_state_nxt = ST_SHOW;
      ST_SHOW:  if (w_wrap)                   w_state_nxt = ST_GUARD;
      default:                                w_state_nxt = ST_GUARD;
    endcase
  end

  // A load that lands on the boundary cycle bypasses the shadow. The new frame
  // then starts with the freshest data.
  always_comb begin
    w_act_val_nxt   = r_act_val;
    w_act_dp_nxt    = r_act_dp;
    w_act_blank_nxt = r_act_blank;
    if (w_frame_bdry) begin
      if (load) begin
        w_act_val_nxt   = value;
        w_act_dp_nxt    = dp_in;
        w_act_blank_nxt = blank;
      end else begin
        w_act_val_nxt   = r_sh_val;
        w_act_dp_nxt    = r_sh_dp;
        w_act_blank_nxt = r_sh_blank;
      end
    end
  end

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
  // Scan from the top digit down. Suppression lasts while every digit seen so
  // far is zero. Digit 0 is never included.
  logic w_lz_run;
  always_comb begin
    w_lz     = '0;
    w_lz_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_lz_run = w_lz_run & (w_act_val_nxt[4*i +: 4] == 4'h0);
      w_lz[i]  = w_lz_run;
    end
  end
`else
  assign w_lz = '0;
`endif

  // Lanes decode the next-cycle active data. The output flops then line up
  // with the prescaler and index they are registered alongside.
  for (genvar g = 0; g < DIGITS; g++) begin : g_lane
    seven_segment_scan_lane u_lane (
      .i_nib   (w_act_val_nxt[4*g +: 4]),
      .i_dp    (w_act_dp_nxt[g]),
      .i_blank (w_act_blank_nxt[g]),
      .i_lz    (w_lz[g]),
      .o_seg   (w_lane_seg[g])
    );
  end

  always_comb begin
    w_seg_hi = 8'h00;
    w_an_hi  = '0;
    if (w_state_nxt == ST_SHOW) begin
      w_seg_hi = w_lane_seg[w_idx_nxt];
      w_an_hi  = AN_ONE << w_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_state     <= ST_GUARD;
      r_sh_val    <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '1;
      r_act_val   <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '1;
      r_seg       <= SEG_OFF;
      r_an        <= AN_OFF;
    end else begin
      r_presc     <= w_presc_nxt;
      r_idx       <= w_idx_nxt;
      r_state     <= w_state_nxt;
      if (load) begin
        r_sh_val   <= value;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank;
      end
      r_act_val   <= w_act_val_nxt;
      r_act_dp    <= w_act_dp_nxt;
      r_act_blank <= w_act_blank_nxt;
      r_seg       <= w_seg_hi ^ SEG_OFF;
      r_an        <= w_an_hi ^ AN_OFF;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule
